pe_out_collector: RTL and testbench

PE_OUT_COLLECTOR -- requirements
Module: pe_out_collector

---
 rtl/pe_out_collector_pkg.sv | 28 ++
 rtl/psum_narrow.sv | 36 +++
 rtl/pe_out_collector.sv | 159 +++++++++++++++
 tb/tb_pe_out_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_out_collector_pkg.sv
// Shared types and helpers for the PE output collector.
package pe_out_collector_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_PEND = 2'd2
  } state_e;

  // Full-precision PSUM width for the default configuration.
  localparam int unsigned DEF_PSUM_WIDTH = 16;

  // Width of one PE result: feature width plus weight width.
  function automatic int unsigned psum_width(input int unsigned i_w, input int unsigned f_w);
    return i_w + f_w;
  endfunction

  // Largest value representable in a signed w-bit word.
  function automatic longint signed sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed w-bit word.
  function automatic longint signed sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/psum_narrow.sv
// Combinational narrowing of a signed PSUM to the output word width.
// PE_OUT_COLLECTOR_SAT_EN defined: saturate; undefined: two's-complement truncation.
module psum_narrow
  import pe_out_collector_pkg::*;
#(
  parameter int unsigned P_WIDTH = DEF_PSUM_WIDTH,
  parameter int unsigned O_WIDTH = 16
) (
  input  logic signed [P_WIDTH-1:0] in_i,
  output logic signed [O_WIDTH-1:0] out_o
);

  if (O_WIDTH == P_WIDTH) begin : g_pass
    assign out_o = in_i;
  end else begin : g_narrow
`ifdef PE_OUT_COLLECTOR_SAT_EN
    // Clamp to the signed output range.
    always_comb begin
      out_o = in_i[O_WIDTH-1:0];
      if (longint'(in_i) > sat_max(O_WIDTH)) begin
        out_o = O_WIDTH'(sat_max(O_WIDTH));
      end else if (longint'(in_i) < sat_min(O_WIDTH)) begin
        out_o = O_WIDTH'(sat_min(O_WIDTH));
      end
    end
`else
    logic unused_hi;
    assign unused_hi = ^in_i[P_WIDTH-1:O_WIDTH];
    // Keep the low bits only.
    always_comb begin
      out_o = in_i[O_WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/pe_out_collector.sv
// Double-buffered snapshot of N PE results, drained one word per transfer.
// Narrowing mode selected by PE_OUT_COLLECTOR_SAT_EN (see psum_narrow).
module pe_out_collector
  import pe_out_collector_pkg::*;
#(
  parameter int unsigned I_WIDTH   = 8,
  parameter int unsigned F_WIDTH   = 8,
  parameter int unsigned N         = 3,
  parameter int unsigned O_WIDTH   = 16,
  parameter int unsigned IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [N*(I_WIDTH+F_WIDTH)-1:0]       pe_out_i,
  input  logic                                 capture_i,
  input  logic                                 out_ready_i,
  output logic                                 out_valid_o,
  output logic signed [O_WIDTH-1:0]            out_data_o,
  output logic [IDX_WIDTH-1:0]                 out_idx_o,
  output logic                                 out_last_o,
  output logic                                 busy_o,
  output logic                                 overflow_o
);

  localparam int unsigned PSUM_W = psum_width(I_WIDTH, F_WIDTH);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  sel_q, sel_d;     // buffer currently being drained
  logic [1:0]            bval_q, bval_d;
  logic                  ovf_q, ovf_d;
  logic [PSUM_W-1:0]     buf_q [2][N];

  logic                  wr_en;
  logic                  wr_sel;
  logic                  is_last;
  logic                  xfer;
  logic                  last_xfer;
  logic [PSUM_W-1:0]     rd_word;
  logic signed [O_WIDTH-1:0] narrow_w;

  assign is_last   = (idx_q == IDX_WIDTH'(N - 1));
  assign xfer      = out_valid_o && out_ready_i;
  assign last_xfer = xfer && is_last;

  // Next state: buffer bookkeeping, read index and capture acceptance.
  // On a last transfer the drained buffer is freed first, so a same-cycle
  // capture always has a free buffer to land in.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    bval_d  = bval_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_sel  = sel_q;
    if (xfer) begin
      idx_d = is_last ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (capture_i) begin
          wr_en          = 1'b1;
          wr_sel         = sel_q;
          bval_d[sel_q]  = 1'b1;
          idx_d          = '0;
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          bval_d[sel_q] = 1'b0;
        end
        if (capture_i) begin
          wr_en          = 1'b1;
          wr_sel         = ~sel_q;
          bval_d[~sel_q] = 1'b1;
          if (last_xfer) begin
            sel_d   = ~sel_q;
            state_d = DRAIN;
          end else begin
            state_d = DRAIN_PEND;
          end
        end else if (last_xfer) begin
          state_d = IDLE;
        end
      end
      DRAIN_PEND: begin
        if (last_xfer) begin
          bval_d[sel_q] = 1'b0;
          sel_d         = ~sel_q;
          state_d       = DRAIN;
          if (capture_i) begin
            wr_en         = 1'b1;
            wr_sel        = sel_q;
            bval_d[sel_q] = 1'b1;
            state_d       = DRAIN_PEND;
          end
        end else if (capture_i) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= 1'b0;
      bval_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      bval_q  <= bval_d;
      ovf_q   <= ovf_d;
    end
  end

  // Snapshot buffers: copy all N slices into the selected buffer on capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned r = 0; r < N; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int unsigned r = 0; r < N; r++) begin
        buf_q[wr_sel][r] <= pe_out_i[r*PSUM_W +: PSUM_W];
      end
    end
  end

  assign rd_word = buf_q[sel_q][idx_q];

  psum_narrow #(
    .P_WIDTH (PSUM_W),
    .O_WIDTH (O_WIDTH)
  ) u_narrow (
    .in_i  (rd_word),
    .out_o (narrow_w)
  );

  // Outputs are forced to zero whenever nothing is being emitted.
  always_comb begin
    busy_o      = (state_q != IDLE);
    out_valid_o = busy_o;
    out_data_o  = out_valid_o ? narrow_w : '0;
    out_idx_o   = out_valid_o ? idx_q : '0;
    out_last_o  = out_valid_o && is_last;
    overflow_o  = ovf_q;
  end

endmodule

// File: tb/tb_pe_out_collector.sv
module tb_pe_out_collector;

  typedef struct {
    logic signed [15:0] data;
    logic [1:0]         idx;
    logic               last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [47:0] pe_out = '0;
  logic        capture = 1'b0;
  logic        ready = 1'b0;
  logic        out_valid;
  logic signed [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last, busy, overflow;

  logic [47:0] pe_out2 = '0;
  logic        capture2 = 1'b0;
  logic        ready2 = 1'b1;
  logic        out_valid2;
  logic signed [7:0] out_data2;
  logic [1:0]  out_idx2;
  logic        out_last2, busy2, overflow2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  logic gap_watch = 1'b0;

  always #5 clk = ~clk;

  pe_out_collector #(
    .I_WIDTH(8), .F_WIDTH(8), .N(3), .O_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .pe_out_i(pe_out), .capture_i(capture),
    .out_ready_i(ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_idx_o(out_idx), .out_last_o(out_last), .busy_o(busy),
    .overflow_o(overflow)
  );

  pe_out_collector #(
    .I_WIDTH(8), .F_WIDTH(8), .N(3), .O_WIDTH(8)
  ) dut_n8 (
    .clk_i(clk), .rst_i(rst_i), .pe_out_i(pe_out2), .capture_i(capture2),
    .out_ready_i(ready2), .out_valid_o(out_valid2), .out_data_o(out_data2),
    .out_idx_o(out_idx2), .out_last_o(out_last2), .busy_o(busy2),
    .overflow_o(overflow2)
  );

  // Monitor for the 16-bit instance: pops on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (gap_watch) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL gap: out_valid=%0b required 1 at %0t", out_valid, $time);
      end
    end
    if (out_valid && ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon1_unexpected: data=%0d idx=%0d with empty scoreboard", out_data, out_idx);
      end else begin
        e = q1.pop_front();
        if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
          errors++;
          $display("FAIL mon1_word: got data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                   out_data, out_idx, out_last, e.data, e.idx, e.last);
        end
        if (q1.size() == 0) gap_watch = 1'b0;
      end
    end
  end

  // Monitor for the 8-bit narrowing instance.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid2 && ready2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL mon2_unexpected: data=%0d idx=%0d with empty scoreboard", out_data2, out_idx2);
      end else begin
        e = q2.pop_front();
        if (16'($signed(out_data2)) !== e.data || out_idx2 !== e.idx || out_last2 !== e.last) begin
          errors++;
          $display("FAIL mon2_word: got data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                   out_data2, out_idx2, out_last2, e.data, e.idx, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push(ref exp_t q[$], input int v, input int i, input logic l);
    exp_t e;
    e.data = 16'(v);
    e.idx  = 2'(i);
    e.last = l;
    q.push_back(e);
  endtask

  // Present three row values, strobe capture for one edge, optionally expect them.
  task automatic cap1(input int v0, input int v1, input int v2, input bit exp_it);
    pe_out  = {16'(v2), 16'(v1), 16'(v0)};
    capture = 1'b1;
    if (exp_it) begin
      push(q1, v0, 0, 1'b0);
      push(q1, v1, 1, 1'b0);
      push(q1, v2, 2, 1'b1);
    end
    tick();
    capture = 1'b0;
  endtask

  task automatic wait_q1();
    int n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", q1.size());
      q1.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_i = 1'b1;
    tick();

    // Single snapshot, ready held high
    ready = 1'b1;
    cap1(5, -7, 300, 1'b1);
    wait_q1();
    tick();
    chk("s1_busy_after", busy, 0);
    chk("s1_valid_after", out_valid, 0);

    // Two snapshots two cycles apart: six words, no bubble
    cap1(1, 2, 3, 1'b1);
    gap_watch = 1'b1;
    tick();
    cap1(4, 5, 6, 1'b1);
    wait_q1();
    repeat (2) tick();

    // Three captures with ready low: third is dropped
    ready = 1'b0;
    cap1(10, 11, 12, 1'b1);
    cap1(20, 21, 22, 1'b1);
    chk("s3_ovf_before", overflow, 0);
    cap1(30, 31, 32, 1'b0);
    chk("s3_ovf", overflow, 1);
    chk("s3_busy", busy, 1);
    ready = 1'b1;
    wait_q1();
    repeat (3) tick();
    chk("s3_ovf_sticky", overflow, 1);
    chk("s3_idle", busy, 0);

    // Backpressure mid-drain holds the word
    cap1(100, 200, -300, 1'b1);
    tick();
    ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 200);
      chk("hold_idx", out_idx, 1);
      chk("hold_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    wait_q1();
    repeat (2) tick();

    // Narrowing to 8 bits
    pe_out2 = {16'(-5), 16'(-200), 16'(300)};
`ifdef PE_OUT_COLLECTOR_SAT_EN
    push(q2, 127, 0, 1'b0);
    push(q2, -128, 1, 1'b0);
`else
    push(q2, 44, 0, 1'b0);
    push(q2, 56, 1, 1'b0);
`endif
    push(q2, -5, 2, 1'b1);
    capture2 = 1'b1;
    tick();
    capture2 = 1'b0;
    repeat (5) tick();
    chk("n8_drained", q2.size(), 0);
    chk("n8_busy", busy2, 0);

    // Reset in the middle of a drain
    cap1(7, 8, 9, 1'b1);
    tick();
    chk("rst_mid_idx", out_idx, 1);
    q1.delete();
    rst_i = 1'b0;
    #1;
    chk("rstm_valid", out_valid, 0);
    chk("rstm_data", out_data, 0);
    chk("rstm_idx", out_idx, 0);
    chk("rstm_last", out_last, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_ovf", overflow, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_valid", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
